// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue core and its front end.
// Key/value layout, the reserved sentinel key and the request record
// carried through the front-end request FIFO.
package pq_pkg;

    localparam int KEY_WIDTH   = 4;
    localparam int VAL_WIDTH   = 4;
    localparam bit MIN_PQ      = 1'b1;
    localparam int PQ_CAPACITY = 15;

    // Sentinel key: the "worst" key for the queue ordering, never stored.
    localparam logic [KEY_WIDTH-1:0] KEYINF = MIN_PQ ? '1 : '0;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    localparam kv_t KV_EMPTY = '{key: KEYINF, val: '0};

    typedef enum logic {OP_ENQ, OP_DEQ} pq_op_t;

    typedef struct packed {
        pq_op_t op;
        kv_t    kv;
    } pq_req_t;

    // True when the pair carries the reserved sentinel key.
    function automatic logic is_sentinel(input kv_t kv);
        return kv.key == KEYINF;
    endfunction

endpackage

// File: rtl/pq_req_fifo.sv
// Request FIFO for pq_front_end. Stores pq_req_t records in arrival order.
// A push is still taken when full if a pop happens in the same cycle.
module pq_req_fifo
    import pq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  pq_req_t din,
    output pq_req_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    pq_req_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pq_front_end.sv
// Request front end for a priority-queue core: buffers ENQ/DEQ requests,
// issues them one at a time, tracks core occupancy and returns one response
// per request. Optional statistics counters are built when PQ_FE_STATS_EN
// is defined.
module pq_front_end
    import pq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CAPACITY   = PQ_CAPACITY
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  pq_op_t       req_op,
    input  kv_t          req_kv,
    output logic         pq_enq,
    output logic         pq_deq,
    output kv_t          pq_kvi,
    input  kv_t          pq_kvo,
    input  logic         pq_busy,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output kv_t          rsp_kv,
    output logic         rsp_err
`ifdef PQ_FE_STATS_EN
    ,output logic [15:0] stat_enq
    ,output logic [15:0] stat_deq
    ,output logic [15:0] stat_err
`endif
);

    localparam int CW = $clog2(CAPACITY + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] count;
    pq_op_t        cur_op;
    kv_t           cur_kv;
    kv_t           rsp_kv_q;
    logic          rsp_err_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    pq_req_t       fifo_din;
    pq_req_t       head;
    logic          check_err;

    assign fifo_din  = '{op: req_op, kv: req_kv};
    assign fifo_pop  = (state == S_CHECK);
    assign req_ready = rst_n && (!fifo_full || fifo_pop);
    assign fifo_push = req_valid && req_ready;

    pq_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Decide whether the head request must be rejected without touching the core.
    always_comb begin
        check_err = 1'b0;
        if (head.op == OP_ENQ)
            check_err = (count == CW'(CAPACITY)) || is_sentinel(head.kv);
        else
            check_err = (count == '0);
    end

    // Core strobes are only raised in ISSUE on a cycle where the core is free.
    always_comb begin
        pq_enq = (state == S_ISSUE) && !pq_busy && (cur_op == OP_ENQ);
        pq_deq = (state == S_ISSUE) && !pq_busy && (cur_op == OP_DEQ);
        pq_kvi = pq_enq ? cur_kv : KV_EMPTY;
    end

    // Response outputs read as idle values outside the RESP state.
    always_comb begin
        rsp_valid = (state == S_RESP);
        rsp_kv    = rsp_valid ? rsp_kv_q : KV_EMPTY;
        rsp_err   = rsp_valid && rsp_err_q;
    end

    // Sequencer: one op at a time, occupancy tracking and response capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            cur_op    <= OP_ENQ;
            cur_kv    <= KV_EMPTY;
            rsp_kv_q  <= KV_EMPTY;
            rsp_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) state <= S_CHECK;
                end
                S_CHECK: begin
                    cur_op <= head.op;
                    cur_kv <= head.kv;
                    if (check_err) begin
                        rsp_kv_q  <= KV_EMPTY;
                        rsp_err_q <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!pq_busy) begin
                        if (cur_op == OP_ENQ) begin
                            count    <= count + CW'(1);
                            rsp_kv_q <= cur_kv;
                        end else begin
                            count    <= count - CW'(1);
                            rsp_kv_q <= pq_kvo;
                        end
                        rsp_err_q <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!pq_busy) state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) state <= fifo_empty ? S_IDLE : S_CHECK;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PQ_FE_STATS_EN
    // Saturating counters of successful ENQs, successful DEQs and rejected ops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_enq <= '0;
            stat_deq <= '0;
            stat_err <= '0;
        end else begin
            if (pq_enq && (stat_enq != 16'hFFFF)) stat_enq <= stat_enq + 16'd1;
            if (pq_deq && (stat_deq != 16'hFFFF)) stat_deq <= stat_deq + 16'd1;
            if ((state == S_CHECK) && check_err && (stat_err != 16'hFFFF))
                stat_err <= stat_err + 16'd1;
        end
    end
`endif

endmodule
